// File: rtl/div_sqrt_iter_engine_pkg.sv
// Shared types and helpers for the radix-2 mantissa divide/square-root engine.
package div_sqrt_iter_engine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  typedef enum logic {
    OP_DIV,
    OP_SQRT
  } op_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_sqrt_iter_engine_if.sv
// Start/kill handshake, operands and result bus of the divide/sqrt engine.
interface div_sqrt_iter_engine_if #(
  parameter int unsigned WIDTH = 25
) ();

  logic             Div_start_SI;
  logic             Sqrt_start_SI;
  logic             Kill_SI;
  logic             Sqrt_shift_SI;
  logic [WIDTH-1:0] Operand_a_DI;
  logic [WIDTH-1:0] Operand_b_DI;
  logic             Ready_SO;
  logic             Done_SO;
  logic [WIDTH-1:0] Result_DO;
  logic             Sticky_SO;

  modport master (
    output Div_start_SI, Sqrt_start_SI, Kill_SI, Sqrt_shift_SI, Operand_a_DI, Operand_b_DI,
    input  Ready_SO, Done_SO, Result_DO, Sticky_SO
  );

  modport slave (
    input  Div_start_SI, Sqrt_start_SI, Kill_SI, Sqrt_shift_SI, Operand_a_DI, Operand_b_DI,
    output Ready_SO, Done_SO, Result_DO, Sticky_SO
  );

endinterface

// File: rtl/div_sqrt_iter_engine_step.sv
// Per-step add/subtract: sum = a + (inv ? ~b : b) + cin, with carry out.
module div_sqrt_iter_engine_step #(
  parameter int unsigned DW = 27
) (
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic          invert_b,
  input  logic          carry_in,
  output logic [DW-1:0] sum,
  output logic          carry_out
);

  logic [DW-1:0] b_eff;
  logic [DW:0]   full;

  assign b_eff     = invert_b ? ~op_b : op_b;
  assign full      = {1'b0, op_a} + {1'b0, b_eff} + {{DW{1'b0}}, carry_in};
  assign sum       = full[DW-1:0];
  assign carry_out = full[DW];

endmodule

// File: rtl/div_sqrt_iter_engine.sv
// Sequential radix-2 mantissa divider (non-restoring) and square root (restoring),
// one digit per cycle through a single shared add/subtract step.
module div_sqrt_iter_engine
  import div_sqrt_iter_engine_pkg::*;
#(
  parameter int unsigned WIDTH = 25
) (
  input logic                  Clk_CI,
  input logic                  Rst_RI,
  div_sqrt_iter_engine_if.slave bus
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned RW = WIDTH + 2;

  state_e             state_q, state_d;
  op_e                op_q;
  logic [CW-1:0]      cnt_q;
  logic [RW-1:0]      rem_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] rad_q;
  logic [WIDTH-1:0]   result_q;
  logic               sticky_q;

  logic               load, step, finish;
  logic               first;
  logic [RW-1:0]      add_a, add_b, add_sum;
  logic               add_inv, add_cin, add_cout;
  logic [RW-1:0]      rem_d;
  logic               q_bit;
  logic               sticky_d;

  assign first = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Kill beats a start in every state; in IDLE that simply means nothing launches.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.Kill_SI && (bus.Div_start_SI || bus.Sqrt_start_SI)) begin
          load    = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        if (bus.Kill_SI) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == '0) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sqrt keeps R <= 2Q, so {R, two bits} always fits in RW bits as an unsigned
  // value and the carry out is the "T >= 0" decision.
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_inv  = 1'b1;
    add_cin  = 1'b1;
    rem_d    = rem_q;
    q_bit    = 1'b0;
    sticky_d = 1'b0;
    if (op_q == OP_DIV) begin
      add_a    = first ? rem_q : {rem_q[RW-2:0], 1'b0};
      add_b    = {2'b00, b_q};
      add_inv  = first | ~rem_q[RW-1];
      add_cin  = add_inv;
      rem_d    = add_sum;
      q_bit    = ~add_sum[RW-1];
      sticky_d = add_sum[RW-1] ? ((add_sum + {2'b00, b_q}) != '0) : (add_sum != '0);
    end else begin
      add_a    = {rem_q[RW-3:0], rad_q[2*WIDTH-1 -: 2]};
      add_b    = {q_q, 2'b01};
      add_inv  = 1'b1;
      add_cin  = 1'b1;
      q_bit    = add_cout;
      rem_d    = add_cout ? add_sum : add_a;
      sticky_d = (rem_d != '0);
    end
  end

  div_sqrt_iter_engine_step #(
    .DW(RW)
  ) u_div_sqrt_step (
    .op_a     (add_a),
    .op_b     (add_b),
    .invert_b (add_inv),
    .carry_in (add_cin),
    .sum      (add_sum),
    .carry_out(add_cout)
  );

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      op_q     <= OP_DIV;
      cnt_q    <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      b_q      <= '0;
      rad_q    <= '0;
      result_q <= '0;
      sticky_q <= 1'b0;
    end else if (load) begin
      op_q  <= bus.Div_start_SI ? OP_DIV : OP_SQRT;
      cnt_q <= CW'(WIDTH - 1);
      rem_q <= bus.Div_start_SI ? {2'b00, bus.Operand_a_DI} : '0;
      q_q   <= '0;
      b_q   <= bus.Operand_b_DI;
      rad_q <= bus.Sqrt_shift_SI ? {bus.Operand_a_DI, {WIDTH{1'b0}}}
                                 : {1'b0, bus.Operand_a_DI, {(WIDTH-1){1'b0}}};
    end else if (step) begin
      cnt_q <= cnt_q - CW'(1);
      rem_q <= rem_d;
      q_q   <= {q_q[WIDTH-2:0], q_bit};
      rad_q <= {rad_q[2*WIDTH-3:0], 2'b00};
      if (finish) begin
        result_q <= {q_q[WIDTH-2:0], q_bit};
        sticky_q <= sticky_d;
      end
    end
  end

  assign bus.Ready_SO  = (state_q == IDLE);
  assign bus.Done_SO   = (state_q == DONE) && !bus.Kill_SI;
  assign bus.Result_DO = result_q;
  assign bus.Sticky_SO = sticky_q;

endmodule

// File: tb/tb_div_sqrt_iter_engine.sv
// Randomized and directed checks of div_sqrt_iter_engine against an arithmetic model.
module tb_div_sqrt_iter_engine;

  localparam int unsigned W = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  div_sqrt_iter_engine_if #(.WIDTH(W)) bus ();

  div_sqrt_iter_engine #(.WIDTH(W)) dut (
    .Clk_CI(clk),
    .Rst_RI(rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] isqrt(input logic [63:0] x);
    logic [63:0] lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 26;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= x) lo = mid;
      else                hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit sh, output logic [W-1:0] r, output logic s);
    logic [63:0] x, q;
    if (is_div) begin
      x = 64'(a) << (W - 1);
      q = x / 64'(b);
      r = W'(q);
      s = (x % 64'(b)) != 0;
    end else begin
      x = sh ? (64'(a) << W) : (64'(a) << (W - 1));
      q = isqrt(x);
      r = W'(q);
      s = (q * q) != x;
    end
  endtask

  task automatic clear_inputs();
    bus.Div_start_SI  = 1'b0;
    bus.Sqrt_start_SI = 1'b0;
    bus.Kill_SI       = 1'b0;
  endtask

  // Launch one op at edge 0 and follow it to Done; optional extra start at cycle inj.
  task automatic run_op(input bit dv, input bit sq, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit sh, input int inj,
                        output logic [W-1:0] res, output logic stk);
    int done_cyc;
    bit ready_ok;
    @(negedge clk);
    bus.Div_start_SI  = dv;
    bus.Sqrt_start_SI = sq;
    bus.Sqrt_shift_SI = sh;
    bus.Operand_a_DI  = a;
    bus.Operand_b_DI  = b;
    @(posedge clk);
    #1;
    clear_inputs();
    done_cyc = -1;
    ready_ok = 1'b1;
    res      = bus.Result_DO;
    stk      = bus.Sticky_SO;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      clear_inputs();
      if (bus.Ready_SO) ready_ok = 1'b0;
      if (bus.Done_SO) begin
        done_cyc = c;
        res      = bus.Result_DO;
        stk      = bus.Sticky_SO;
      end else if (c == inj) begin
        bus.Div_start_SI  = 1'b1;
        bus.Sqrt_start_SI = 1'b1;
        bus.Operand_a_DI  = a ^ 25'h0F0F0F;
        bus.Operand_b_DI  = 25'h1000000;
      end
    end
    clear_inputs();
    check("done_cycle", 64'(done_cyc), 64'(W + 1));
    check("ready_low_while_busy", 64'(ready_ok), 64'd1);
    @(negedge clk);
    check("ready_after_done", 64'(bus.Ready_SO), 64'd1);
    check("done_single_pulse", 64'(bus.Done_SO), 64'd0);
    check("result_held", 64'(bus.Result_DO), 64'(res));
  endtask

  task automatic directed(input string tag, input bit dv, input bit sq, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit sh,
                          input logic [W-1:0] exp_r, input logic exp_s);
    logic [W-1:0] r;
    logic         s;
    run_op(dv, sq, a, b, sh, 0, r, s);
    check({tag, "_result"}, 64'(r), 64'(exp_r));
    check({tag, "_sticky"}, 64'(s), 64'(exp_s));
  endtask

  task automatic kill_test(input bit with_start);
    logic [W-1:0] prev;
    bit           done_seen;
    bit           ready_ok;
    prev = bus.Result_DO;
    @(negedge clk);
    bus.Div_start_SI = 1'b1;
    bus.Operand_a_DI = 25'h1FFFFFF;
    bus.Operand_b_DI = 25'h1000001;
    @(posedge clk);
    #1;
    clear_inputs();
    for (int c = 1; c <= 10; c++) @(negedge clk);
    bus.Kill_SI = 1'b1;
    if (with_start) bus.Div_start_SI = 1'b1;
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    check(with_start ? "kill_start_idle" : "kill_idle", 64'(bus.Ready_SO), 64'd1);
    done_seen = 1'b0;
    ready_ok  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.Done_SO) done_seen = 1'b1;
      if (!bus.Ready_SO) ready_ok = 1'b0;
    end
    check(with_start ? "kill_start_no_done" : "kill_no_done", 64'(done_seen), 64'd0);
    check(with_start ? "kill_start_no_launch" : "kill_stays_idle", 64'(ready_ok), 64'd1);
    check(with_start ? "kill_start_result" : "kill_result", 64'(bus.Result_DO), 64'(prev));
  endtask

  initial begin
    logic [W-1:0] a, b, r, er;
    logic         s, es, sh;
    bit           dv, seen;

    clear_inputs();
    bus.Sqrt_shift_SI = 1'b0;
    bus.Operand_a_DI  = '0;
    bus.Operand_b_DI  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.Ready_SO), 64'd1);
    check("rst_done", 64'(bus.Done_SO), 64'd0);
    check("rst_result", 64'(bus.Result_DO), 64'd0);
    check("rst_sticky", 64'(bus.Sticky_SO), 64'd0);
    rst = 1'b0;

    directed("div_1_1",     1, 0, 25'h1000000, 25'h1000000, 0, 25'h1000000, 0);
    directed("div_1_1p5",   1, 0, 25'h1000000, 25'h1800000, 0, 25'h0AAAAAA, 1);
    directed("div_1p5_1",   1, 0, 25'h1800000, 25'h1000000, 0, 25'h1800000, 0);
    directed("sqrt_1",      0, 1, 25'h1000000, 25'h0,       0, 25'h1000000, 0);
    directed("sqrt_2",      0, 1, 25'h1000000, 25'h0,       1, 25'h16A09E6, 1);
    directed("both_starts", 1, 1, 25'h1800000, 25'h1000000, 0, 25'h1800000, 0);

    // Starts during ITER are dropped, not queued.
    run_op(0, 1, 25'h1234567, 25'h0, 1, 5, r, s);
    model(0, 25'h1234567, 25'h0, 1, er, es);
    check("iter_start_result", 64'(r), 64'(er));
    check("iter_start_sticky", 64'(s), 64'(es));
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.Done_SO || !bus.Ready_SO) seen = 1'b1;
    end
    check("iter_start_not_queued", 64'(seen), 64'd0);

    kill_test(1'b0);
    kill_test(1'b1);

    // Kill while in DONE drops the pulse but the new result has already landed.
    @(negedge clk);
    bus.Div_start_SI = 1'b1;
    bus.Operand_a_DI = 25'h1800000;
    bus.Operand_b_DI = 25'h1000000;
    @(posedge clk);
    #1;
    clear_inputs();
    for (int c = 1; c <= W + 1; c++) @(negedge clk);
    bus.Kill_SI = 1'b1;
    #1;
    check("kill_done_pulse", 64'(bus.Done_SO), 64'd0);
    check("kill_done_result", 64'(bus.Result_DO), 64'h1800000);
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    check("kill_done_idle", 64'(bus.Ready_SO), 64'd1);

    // Reset mid-operation.
    @(negedge clk);
    bus.Sqrt_start_SI = 1'b1;
    bus.Operand_a_DI  = 25'h1ABCDEF;
    @(posedge clk);
    #1;
    clear_inputs();
    for (int c = 1; c <= 5; c++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(bus.Ready_SO), 64'd1);
    check("midrst_done", 64'(bus.Done_SO), 64'd0);
    check("midrst_result", 64'(bus.Result_DO), 64'd0);
    check("midrst_sticky", 64'(bus.Sticky_SO), 64'd0);
    directed("after_rst", 1, 0, 25'h1000000, 25'h1800000, 0, 25'h0AAAAAA, 1);

    for (int i = 0; i < 40; i++) begin
      dv = 1'($urandom_range(0, 1));
      sh = 1'($urandom_range(0, 1));
      a  = {1'b1, 24'($urandom)};
      b  = {1'b1, 24'($urandom)};
      if (i == 0) begin a = 25'h1FFFFFF; b = 25'h1000000; end
      if (i == 1) begin a = 25'h1000000; b = 25'h1FFFFFF; end
      if (i == 2) begin a = 25'h1FFFFFF; b = 25'h1FFFFFF; end
      if (i == 3) begin a = 25'h1FFFFFF; dv = 1'b0; sh = 1'b1; end
      model(dv, a, b, sh, er, es);
      run_op(dv, !dv, a, b, sh, 0, r, s);
      check(dv ? "rand_div_result" : "rand_sqrt_result", 64'(r), 64'(er));
      check(dv ? "rand_div_sticky" : "rand_sqrt_sticky", 64'(s), 64'(es));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/div_sqrt_iter_engine.md
# div_sqrt_iter_engine

Sequential mantissa divide/square-root engine for the FPU datapath. It accepts one normalized mantissa operation at a time, runs one radix-2 digit-recurrence step per cycle, and returns a WIDTH-bit quotient or root plus a sticky bit to the rounding stage. It is the control and accumulation side of the per-step add/subtract datapath: it builds the operands and carry-in for each step and consumes the step's sum and carry.

## Interface
- WIDTH, 25, mantissa width including the hidden bit; also the number of result bits and iterations.
- Clk_CI  in  1  clock.
- Rst_RI  in  1  reset; synchronous, active-high.
- Div_start_SI  in  1  start a divide; sampled only in IDLE.
- Sqrt_start_SI  in  1  start a square root; sampled only in IDLE.
- Kill_SI  in  1  abort the current operation.
- Sqrt_shift_SI  in  1  odd exponent for sqrt, sampled with the start.
- Operand_a_DI  in  WIDTH  dividend or radicand mantissa; MSB set.
- Operand_b_DI  in  WIDTH  divisor mantissa; MSB set; ignored for sqrt.
- Ready_SO  out  1  high in IDLE.
- Done_SO  out  1  one-cycle pulse when the result is valid.
- Result_DO  out  WIDTH  quotient or root; held until the next start.
- Sticky_SO  out  1  final remainder is nonzero; held with Result_DO.

## Operation
- FSM states:
  - IDLE: a start moves to ITER and loads the operands. Iteration counter = WIDTH-1. Op is latched.
  - ITER: performs one step per cycle. Counter 0 moves to DONE.
  - DONE: Done_SO=1, then IDLE unconditionally.
- Start and kill rules:
  - Both starts high: divide wins.
  - Starts outside IDLE are ignored, with no queuing.
- Divide (non-restoring): remainder R is WIDTH+2 bits, signed.
  - Step 1: R = A - B.
  - Later steps: R = 2R - B if R≥0, else 2R + B.
  - Each step shifts in result bit (R_new ≥ 0), MSB first.
  - Result = floor(A·2^(WIDTH-1)/B).
  - Sticky = (R<0 ? R+B : R) ≠ 0.
- Sqrt (restoring, bit-serial):
  - Radicand X is 2·WIDTH bits: A<<(WIDTH-1), or A<<WIDTH when Sqrt_shift_SI is set.
  - Each step consumes the next 2 bits of X, MSB first: T = (R<<2 | bits) - (Q<<2 | 1).
  - If T≥0: R=T, Q=Q<<1|1. Else: R=R<<2|bits, Q=Q<<1.
  - R is WIDTH+2 bits.
  - Result = floor(sqrt(X)). Sticky = R≠0.
- Every step uses one add with carry-in: subtraction is B inverted with carry-in 1. The step's carry out gives the sign.
- Illegal operands (MSB clear, B=0): the result is undefined, but the FSM timing is unchanged and no hang is allowed.

## Timing
- Reset values: state IDLE, Ready_SO=1, Done_SO=0, Result_DO=0, Sticky_SO=0, counter=0, remainder=0.
- Latency:
  - Start accepted at edge 0.
  - WIDTH ITER cycles.
  - Done_SO high during cycle WIDTH+1 (cycle 26 for WIDTH=25).
  - Earliest next start is cycle WIDTH+2.
- Result_DO and Sticky_SO update in the same edge that enters DONE. They are stable while Done_SO is high and afterwards.
- Kill_SI:
  - In ITER or DONE: IDLE on the next edge. Done_SO is suppressed (or dropped, if in DONE). Result_DO keeps its previous value.
  - Kill wins over a simultaneous start.
  - Kill in IDLE has no effect.
- Rst_RI mid-operation restores all reset values on the next edge and takes priority over everything.

## Structure
- Shared package:
  - state enum {IDLE, ITER, DONE}.
  - op enum {OP_DIV, OP_SQRT}.
  - function for the iteration-counter width, $clog2(WIDTH).
- One natural sub-module, div_sqrt_step: combinational WIDTH+2-bit adder with operand inversion and carry-in, returning sum and carry. It is instantiated once and reused every cycle.
- Top level holds the FSM, counter, remainder, result shift register and radicand shift register. Target size is about 200–300 lines.

## Test plan
All scenarios use WIDTH=25.
- Div A=0x1000000, B=0x1000000 -> Result 0x1000000, Sticky 0, Done_SO exactly at cycle 26, Ready_SO low in cycles 1–26.
- Div A=0x1000000, B=0x1800000 -> Result 0x0AAAAAA, Sticky 1; Div A=0x1800000, B=0x1000000 -> 0x1800000, Sticky 0.
- Sqrt A=0x1000000, shift 0 -> Result 0x1000000, Sticky 0; with shift 1 -> Result 0x16A09E6, Sticky 1.
- Kill_SI at cycle 10 of a divide -> IDLE at cycle 11, no Done_SO, Result_DO unchanged. Repeat with Kill_SI and a start in the same cycle -> no operation starts.
- Div_start_SI and Sqrt_start_SI asserted together -> divide executes. Starts asserted during ITER -> ignored.
- Rst_RI at cycle 5 -> all outputs at reset values next cycle. A start immediately after reset completes normally.
